// File: rtl/pipe_hazard_ctl.sv
// Hazard and sequencing controller for a 5-stage pipe: load-use stalls, jump/halt
// flushes, registered EX forwarding selects, halt drain and saturating perf counters.
module pipe_hazard_ctl #(
  parameter int REG_WORDS    = 32,
  parameter int ADDR_LEFT    = $clog2(REG_WORDS) - 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_BITS     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEFT:0]  r1_addr_s2,
  input  logic [ADDR_LEFT:0]  r2_addr_s2,
  input  logic                r1_used_s2,
  input  logic                r2_used_s2,
  input  logic [ADDR_LEFT:0]  waddr_s3,
  input  logic                rw_s3,
  input  logic                sel_mem_s3,
  input  logic [ADDR_LEFT:0]  waddr_s4,
  input  logic                rw_s4,
  input  logic                jump_s2,
  input  logic                halt_s2,
  input  logic                mem_busy,
  output logic                stall_s1,
  output logic                stall_s2,
  output logic                bubble_s3,
  output logic                freeze,
  output logic                flush_s2,
  output logic [1:0]          fwd_a_s3,
  output logic [1:0]          fwd_b_s3,
  output logic                halted,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam int DW = $clog2(DRAIN_CYCLES) + 1;

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          match1, match2, lu;

  // rw_s3/rw_s4 are active-low write enables; register 0 never carries a hazard.
  assign match1 = r1_used_s2 & (r1_addr_s2 != '0) & ~rw_s3 & (waddr_s3 == r1_addr_s2);
  assign match2 = r2_used_s2 & (r2_addr_s2 != '0) & ~rw_s3 & (waddr_s3 == r2_addr_s2);
  assign lu     = sel_mem_s3 & (match1 | match2);

  function automatic logic [1:0] fwd_sel(input logic [ADDR_LEFT:0] addr, input logic used);
    if (!used || addr == '0)                fwd_sel = 2'b00;
    else if (!rw_s3 && waddr_s3 == addr)    fwd_sel = 2'b01;
    else if (!rw_s4 && waddr_s4 == addr)    fwd_sel = 2'b10;
    else                                    fwd_sel = 2'b00;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    stall_s1  = 1'b0;
    stall_s2  = 1'b0;
    bubble_s3 = 1'b0;
    freeze    = 1'b0;
    flush_s2  = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        freeze   = 1'b1;
        stall_s1 = 1'b1;
        stall_s2 = 1'b1;
      end else begin
        unique case (state)
          RUN: begin
            if (lu) begin
              stall_s1  = 1'b1;
              stall_s2  = 1'b1;
              bubble_s3 = 1'b1;
            end else if (jump_s2) begin
              flush_s2 = 1'b1;
            end else if (halt_s2) begin
              flush_s2 = 1'b1;
              stall_s1 = 1'b1;
            end
          end
          DRAIN: begin
            stall_s1 = 1'b1;
            flush_s2 = 1'b1;
          end
          HALTED: begin
            stall_s1  = 1'b1;
            stall_s2  = 1'b1;
            bubble_s3 = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      fwd_a_s3  <= 2'b00;
      fwd_b_s3  <= 2'b00;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      unique case (state)
        RUN: begin
          if (!lu && !jump_s2 && halt_s2) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase

      // The bubbled slot entering EX has no operands to forward.
      fwd_a_s3 <= bubble_s3 ? 2'b00 : fwd_sel(r1_addr_s2, r1_used_s2);
      fwd_b_s3 <= bubble_s3 ? 2'b00 : fwd_sel(r2_addr_s2, r2_used_s2);

      if (bubble_s3 && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_BITS'(1);
      if (flush_s2  && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: each driven cycle pushes its expected
// control, forwarding, halt and counter values; a checker pops and compares them.
module tb_pipe_hazard_ctl;

  logic       clk;
  logic       rst;
  logic [4:0] r1_addr_s2, r2_addr_s2, waddr_s3, waddr_s4;
  logic       r1_used_s2, r2_used_s2, rw_s3, sel_mem_s3, rw_s4;
  logic       jump_s2, halt_s2, mem_busy;
  logic       stall_s1, stall_s2, bubble_s3, freeze, flush_s2, halted;
  logic [1:0] fwd_a_s3, fwd_b_s3;
  logic [15:0] stall_cnt, flush_cnt;
  logic       stall_s1_4, stall_s2_4, bubble_s3_4, freeze_4, flush_s2_4, halted_4;
  logic [1:0] fwd_a_4, fwd_b_4;
  logic [3:0] stall_cnt_4, flush_cnt_4;

  pipe_hazard_ctl dut (
    .clk(clk), .rst(rst),
    .r1_addr_s2(r1_addr_s2), .r2_addr_s2(r2_addr_s2),
    .r1_used_s2(r1_used_s2), .r2_used_s2(r2_used_s2),
    .waddr_s3(waddr_s3), .rw_s3(rw_s3), .sel_mem_s3(sel_mem_s3),
    .waddr_s4(waddr_s4), .rw_s4(rw_s4),
    .jump_s2(jump_s2), .halt_s2(halt_s2), .mem_busy(mem_busy),
    .stall_s1(stall_s1), .stall_s2(stall_s2), .bubble_s3(bubble_s3),
    .freeze(freeze), .flush_s2(flush_s2),
    .fwd_a_s3(fwd_a_s3), .fwd_b_s3(fwd_b_s3), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctl #(.CNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst),
    .r1_addr_s2(r1_addr_s2), .r2_addr_s2(r2_addr_s2),
    .r1_used_s2(r1_used_s2), .r2_used_s2(r2_used_s2),
    .waddr_s3(waddr_s3), .rw_s3(rw_s3), .sel_mem_s3(sel_mem_s3),
    .waddr_s4(waddr_s4), .rw_s4(rw_s4),
    .jump_s2(jump_s2), .halt_s2(halt_s2), .mem_busy(mem_busy),
    .stall_s1(stall_s1_4), .stall_s2(stall_s2_4), .bubble_s3(bubble_s3_4),
    .freeze(freeze_4), .flush_s2(flush_s2_4),
    .fwd_a_s3(fwd_a_4), .fwd_b_s3(fwd_b_4), .halted(halted_4),
    .stall_cnt(stall_cnt_4), .flush_cnt(flush_cnt_4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control vector order: {stall_s1, stall_s2, bubble_s3, freeze, flush_s2}
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_LU     = 5'b11100;
  localparam logic [4:0] C_BUSY   = 5'b11010;
  localparam logic [4:0] C_JMP    = 5'b00001;
  localparam logic [4:0] C_HALT   = 5'b10001;
  localparam logic [4:0] C_HALTED = 5'b11100;

  typedef struct {
    logic       rst;
    logic [4:0] r1, r2, w3, w4;
    logic       u1, u2, rw3, mem3, rw4, jmp, hlt, busy;
  } in_t;

  typedef struct {
    string      tag;
    logic [4:0] ctl;
    logic [1:0] fa, fb;
    logic       hltd;
    int         sc, fc;
  } exp_t;

  in_t  in;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in = '{rst: 1'b0, r1: 5'd0, r2: 5'd0, w3: 5'd0, w4: 5'd0,
           u1: 1'b0, u2: 1'b0, rw3: 1'b1, mem3: 1'b0, rw4: 1'b1,
           jmp: 1'b0, hlt: 1'b0, busy: 1'b0};
  endtask

  task automatic run(input string tag, input logic [4:0] ctl, input logic [1:0] fa,
                     input logic [1:0] fb, input logic hltd, input int sc, input int fc);
    exp_t e;
    @(negedge clk);
    rst        = in.rst;
    r1_addr_s2 = in.r1;   r2_addr_s2 = in.r2;
    r1_used_s2 = in.u1;   r2_used_s2 = in.u2;
    waddr_s3   = in.w3;   rw_s3      = in.rw3;  sel_mem_s3 = in.mem3;
    waddr_s4   = in.w4;   rw_s4      = in.rw4;
    jump_s2    = in.jmp;  halt_s2    = in.hlt;  mem_busy   = in.busy;
    e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.hltd = hltd; e.sc = sc; e.fc = fc;
    sb.push_back(e);
  endtask

  // Checker: control outputs mid-cycle, registered outputs just after the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "_ctl"}, 32'({stall_s1, stall_s2, bubble_s3, freeze, flush_s2}), 32'(e.ctl));
        @(posedge clk);
        #1;
        check({e.tag, "_fwd_a"}, 32'(fwd_a_s3), 32'(e.fa));
        check({e.tag, "_fwd_b"}, 32'(fwd_b_s3), 32'(e.fb));
        check({e.tag, "_halted"}, 32'(halted), 32'(e.hltd));
        check({e.tag, "_stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
        check({e.tag, "_flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
        check({e.tag, "_stall_cnt4"}, 32'(stall_cnt_4), 32'((e.sc > 15) ? 15 : e.sc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    in.rst = 1'b1;
    rst = 1'b1;
    r1_addr_s2 = '0; r2_addr_s2 = '0; r1_used_s2 = 0; r2_used_s2 = 0;
    waddr_s3 = '0; rw_s3 = 1; sel_mem_s3 = 0; waddr_s4 = '0; rw_s4 = 1;
    jump_s2 = 0; halt_s2 = 0; mem_busy = 0;

    // Reset with random inputs: everything must read zero.
    for (int i = 0; i < 2; i++) begin
      in.r1 = 5'($urandom); in.r2 = 5'($urandom); in.w3 = 5'($urandom); in.w4 = 5'($urandom);
      in.u1 = 1'($urandom); in.u2 = 1'($urandom); in.rw3 = 1'($urandom); in.mem3 = 1'($urandom);
      in.rw4 = 1'($urandom); in.jmp = 1'($urandom); in.hlt = 1'($urandom); in.busy = 1'($urandom);
      in.rst = 1'b1;
      run("reset", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0);
    end
    idle(); run("idle", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0);

    // Load-use on r5: one stall cycle, then WB forward once the load sits in MEM.
    idle(); in.mem3 = 1; in.rw3 = 0; in.w3 = 5; in.u1 = 1; in.r1 = 5; in.r2 = 5;
    run("lu", C_LU, 2'b00, 2'b00, 1'b0, 1, 0);
    idle(); in.rw4 = 0; in.w4 = 5; in.u1 = 1; in.r1 = 5; in.u2 = 1; in.r2 = 5;
    run("lu_s4", C_NONE, 2'b10, 2'b10, 1'b0, 1, 0);

    // ALU forwarding: younger producer wins, register 0 never forwards, unused source is 00.
    idle(); in.rw3 = 0; in.w3 = 7; in.rw4 = 0; in.w4 = 7; in.u1 = 1; in.r1 = 7; in.u2 = 1; in.r2 = 7;
    run("alu", C_NONE, 2'b01, 2'b01, 1'b0, 1, 0);
    in.r1 = 0;
    run("r0", C_NONE, 2'b00, 2'b01, 1'b0, 1, 0);
    idle(); in.rw3 = 0; in.w3 = 3; in.rw4 = 0; in.w4 = 7; in.u1 = 1; in.r1 = 7; in.r2 = 3;
    run("wb_fwd", C_NONE, 2'b10, 2'b00, 1'b0, 1, 0);

    // Priority: load-use beats jump; jump next cycle; mem_busy freezes everything.
    idle(); in.mem3 = 1; in.rw3 = 0; in.w3 = 9; in.u1 = 1; in.r1 = 9; in.jmp = 1;
    run("lu_jmp", C_LU, 2'b00, 2'b00, 1'b0, 2, 0);
    idle(); in.rw4 = 0; in.w4 = 9; in.u1 = 1; in.r1 = 9; in.jmp = 1;
    run("jmp", C_JMP, 2'b10, 2'b00, 1'b0, 2, 1);
    idle(); in.mem3 = 1; in.rw3 = 0; in.w3 = 9; in.u1 = 1; in.r1 = 9; in.busy = 1;
    run("busy_lu", C_BUSY, 2'b10, 2'b00, 1'b0, 2, 1);
    in.busy = 0;
    run("lu_release", C_LU, 2'b00, 2'b00, 1'b0, 3, 1);

    // Halt: three non-frozen drain cycles, then halted until reset.
    idle(); in.hlt = 1;
    run("halt", C_HALT, 2'b00, 2'b00, 1'b0, 3, 2);
    idle();
    run("drain0", C_HALT, 2'b00, 2'b00, 1'b0, 3, 3);
    in.busy = 1;
    run("drain_busy", C_BUSY, 2'b00, 2'b00, 1'b0, 3, 3);
    in.busy = 0;
    run("drain1", C_HALT, 2'b00, 2'b00, 1'b0, 3, 4);
    run("drain2", C_HALT, 2'b00, 2'b00, 1'b1, 3, 5);
    in.jmp = 1;
    run("halted0", C_HALTED, 2'b00, 2'b00, 1'b1, 4, 5);
    run("halted1", C_HALTED, 2'b00, 2'b00, 1'b1, 5, 5);
    in.rst = 1;
    run("rst_halted", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0);
    idle(); in.jmp = 1;
    run("run_again", C_JMP, 2'b00, 2'b00, 1'b0, 0, 1);

    // Saturation: 20 load-use cycles; the 4-bit counter must stop at 15.
    idle(); in.mem3 = 1; in.rw3 = 0; in.w3 = 5; in.u1 = 1; in.r1 = 5;
    for (int i = 1; i <= 20; i++) run("sat", C_LU, 2'b00, 2'b00, 1'b0, i, 1);

    idle();
    @(negedge clk);
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
